// File: rtl/sweep_pkg.sv
// Shared types and constants for the triangle-sweep scheduler.
package sweep_pkg;

    localparam int unsigned DefWidth  = 32;
    localparam int unsigned DefDwellW = 8;
    localparam int unsigned DefNswW   = 8;

    localparam int unsigned StateW = 3;

    localparam logic [StateW-1:0] StIdleEnc    = 3'd0;
    localparam logic [StateW-1:0] StRiseEnc    = 3'd1;
    localparam logic [StateW-1:0] StDwellHiEnc = 3'd2;
    localparam logic [StateW-1:0] StFallEnc    = 3'd3;
    localparam logic [StateW-1:0] StDwellLoEnc = 3'd4;

    typedef enum logic [StateW-1:0] {
        StIdle    = StIdleEnc,
        StRise    = StRiseEnc,
        StDwellHi = StDwellHiEnc,
        StFall    = StFallEnc,
        StDwellLo = StDwellLoEnc
    } sweep_state_t;

endpackage

// File: rtl/sweep_scheduler_if.sv
// Control/status bundle between a sequencer (master) and the sweep scheduler (slave).
interface sweep_scheduler_if
    import sweep_pkg::*;
#(
    parameter int unsigned WIDTH   = DefWidth,
    parameter int unsigned DWELL_W = DefDwellW,
    parameter int unsigned NSW_W   = DefNswW
) ();

    logic               start;
    logic               abort;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   hi;
    logic [DWELL_W-1:0] dwell;
    logic [NSW_W-1:0]   n_sweeps;
    logic [WIDTH-1:0]   q;
    logic               up;
    logic               busy;
    logic               done;
    logic               err;
    logic [NSW_W-1:0]   sweep_cnt;

    modport master (
        output start, abort, lo, hi, dwell, n_sweeps,
        input  q, up, busy, done, err, sweep_cnt
    );

    modport slave (
        input  start, abort, lo, hi, dwell, n_sweeps,
        output q, up, busy, done, err, sweep_cnt
    );

endinterface

// File: rtl/sweep_dwell_timer.sv
// Dwell down-counter: load in the first hold cycle, expire in the last (len+1 cycles total).
module sweep_dwell_timer #(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [DWELL_W-1:0] len,
    output logic               expire
);

    logic [DWELL_W-1:0] r_cnt;

    // r_cnt holds the hold cycles still remaining after the current one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= (len == '0) ? '0 : len - DWELL_W'(1);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - DWELL_W'(1);
        end
    end

    assign expire = load ? (len == '0) : (r_cnt == '0);

endmodule

// File: rtl/sweep_scheduler.sv
// Triangle sweep controller: lo->hi->lo runs with dwell at each turning point.
module sweep_scheduler
    import sweep_pkg::*;
#(
    parameter int unsigned WIDTH   = DefWidth,
    parameter int unsigned DWELL_W = DefDwellW,
    parameter int unsigned NSW_W   = DefNswW
) (
    input  logic             clk,
    input  logic             reset,
    sweep_scheduler_if.slave bus
);

    sweep_state_t       r_state;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_hi;
    logic [DWELL_W-1:0] r_dwell;
    logic [NSW_W-1:0]   r_nsw;
    logic [NSW_W-1:0]   r_sweep_cnt;
    logic               r_up;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic               r_tmr_load;

    logic               w_expire;
    logic [WIDTH-1:0]   w_q_inc;
    logic [WIDTH-1:0]   w_q_dec;
    logic [NSW_W-1:0]   w_cnt_inc;
    logic               w_last_sweep;

    assign w_q_inc      = r_q + WIDTH'(1);
    assign w_q_dec      = r_q - WIDTH'(1);
    assign w_cnt_inc    = r_sweep_cnt + NSW_W'(1);
    assign w_last_sweep = (r_nsw != '0) && (w_cnt_inc == r_nsw);

    sweep_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (r_tmr_load),
        .len    (r_dwell),
        .expire (w_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StIdle;
            r_q         <= '0;
            r_lo        <= '0;
            r_hi        <= '0;
            r_dwell     <= '0;
            r_nsw       <= '0;
            r_sweep_cnt <= '0;
            r_up        <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_tmr_load  <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_tmr_load <= 1'b0;
            if (r_state != StIdle && bus.abort) begin
                r_state <= StIdle;
                r_busy  <= 1'b0;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        if (bus.start) begin
                            if (bus.lo >= bus.hi) begin
                                r_done <= 1'b1;
                                r_err  <= 1'b1;
                            end else begin
                                r_lo        <= bus.lo;
                                r_hi        <= bus.hi;
                                r_dwell     <= bus.dwell;
                                r_nsw       <= bus.n_sweeps;
                                r_q         <= bus.lo;
                                r_up        <= 1'b1;
                                r_sweep_cnt <= '0;
                                r_busy      <= 1'b1;
                                r_state     <= StRise;
                            end
                        end
                    end
                    StRise: begin
                        r_q <= w_q_inc;
                        if (w_q_inc == r_hi) begin
                            r_state    <= StDwellHi;
                            r_tmr_load <= 1'b1;
                        end
                    end
                    // Leaving the top dwell already takes the first step down.
                    StDwellHi, StFall: begin
                        if (r_state == StFall || w_expire) begin
                            r_up <= 1'b0;
                            r_q  <= w_q_dec;
                            if (w_q_dec == r_lo) begin
                                r_sweep_cnt <= w_cnt_inc;
                                if (w_last_sweep) begin
                                    r_state <= StIdle;
                                    r_busy  <= 1'b0;
                                    r_done  <= 1'b1;
                                end else begin
                                    r_state    <= StDwellLo;
                                    r_tmr_load <= 1'b1;
                                end
                            end else begin
                                r_state <= StFall;
                            end
                        end
                    end
                    StDwellLo: begin
                        if (w_expire) begin
                            r_up    <= 1'b1;
                            r_state <= StRise;
                        end
                    end
                    default: begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.q         = r_q;
    assign bus.up        = r_up;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.sweep_cnt = r_sweep_cnt;

endmodule

// File: tb/tb_sweep_scheduler.sv
// Scoreboard bench for sweep_scheduler: expected per-cycle outputs queued, then compared.
module tb_sweep_scheduler;

    localparam int unsigned W  = 16;
    localparam int unsigned DW = 8;
    localparam int unsigned NW = 8;

    typedef struct packed {
        logic [W-1:0]  q;
        logic          up;
        logic          busy;
        logic          done;
        logic          err;
        logic [NW-1:0] cnt;
    } obs_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    sweep_scheduler_if #(.WIDTH(W), .DWELL_W(DW), .NSW_W(NW)) bus ();

    sweep_scheduler #(
        .WIDTH   (W),
        .DWELL_W (DW),
        .NSW_W   (NW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    obs_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic obs_t mk(int q, int up, int busy, int done, int err, int cnt);
        obs_t o;
        o.q    = W'(q);
        o.up   = up[0];
        o.busy = busy[0];
        o.done = done[0];
        o.err  = err[0];
        o.cnt  = NW'(cnt);
        return o;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.q    = bus.q;
        o.up   = bus.up;
        o.busy = bus.busy;
        o.done = bus.done;
        o.err  = bus.err;
        o.cnt  = bus.sweep_cnt;
        return o;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("q=%0d up=%0b busy=%0b done=%0b err=%0b cnt=%0d",
                         o.q, o.up, o.busy, o.done, o.err, o.cnt);
    endfunction

    task automatic test_reset();
        obs_t got, exp;
        bus.start = 1'b1; bus.abort = 1'b0;
        bus.lo = 16'd1; bus.hi = 16'd3; bus.dwell = 8'd0; bus.n_sweeps = 8'd1;
        reset = 1'b1;
        sb.push_back(mk(0, 1, 0, 0, 0, 0));
        sb.push_back(mk(0, 1, 0, 0, 0, 0));
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            exp = sb.pop_front(); got = observe(); n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset[%0d]: got %s, want %s", i, fmt(got), fmt(exp));
            end
        end
        reset = 1'b0; bus.start = 1'b0;
    endtask

    task automatic test_single_sweep();
        int qv [9] = '{2, 3, 4, 5, 5, 4, 3, 2, 2};
        int uv [9] = '{1, 1, 1, 1, 1, 0, 0, 0, 0};
        obs_t got, exp;
        bus.lo = 16'd2; bus.hi = 16'd5; bus.dwell = 8'd1; bus.n_sweeps = 8'd1;
        bus.start = 1'b1;
        for (int i = 0; i < 9; i++)
            sb.push_back(mk(qv[i], uv[i], (i < 7) ? 1 : 0, (i == 7) ? 1 : 0, 0, (i >= 7) ? 1 : 0));
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            exp = sb.pop_front(); got = observe(); n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL single_sweep[%0d]: got %s, want %s", i, fmt(got), fmt(exp));
            end
            bus.start = 1'b0;
        end
    endtask

    task automatic test_two_sweeps();
        int qv [11] = '{0, 1, 2, 1, 0, 0, 1, 2, 1, 0, 0};
        int uv [11] = '{1, 1, 1, 0, 0, 1, 1, 1, 0, 0, 0};
        int cv [11] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 2, 2};
        obs_t got, exp;
        bus.lo = 16'd0; bus.hi = 16'd2; bus.dwell = 8'd0; bus.n_sweeps = 8'd2;
        bus.start = 1'b1;
        for (int i = 0; i < 11; i++)
            sb.push_back(mk(qv[i], uv[i], (i < 9) ? 1 : 0, (i == 9) ? 1 : 0, 0, cv[i]));
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
            exp = sb.pop_front(); got = observe(); n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL two_sweeps[%0d]: got %s, want %s", i, fmt(got), fmt(exp));
            end
            bus.start = 1'b0;
        end
    endtask

    // Previous run left q=0, up=0, sweep_cnt=2; rejections must not disturb them.
    task automatic test_reject();
        obs_t got, exp;
        bus.lo = 16'd7; bus.hi = 16'd7; bus.dwell = 8'd3; bus.n_sweeps = 8'd1;
        bus.start = 1'b1;
        sb.push_back(mk(0, 0, 0, 1, 1, 2));
        sb.push_back(mk(0, 0, 0, 0, 0, 2));
        sb.push_back(mk(0, 0, 0, 1, 1, 2));
        sb.push_back(mk(0, 0, 0, 0, 0, 2));
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            exp = sb.pop_front(); got = observe(); n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reject[%0d]: got %s, want %s", i, fmt(got), fmt(exp));
            end
            bus.start = (i == 1);
            if (i == 1) begin
                bus.lo = 16'd9; bus.hi = 16'd3;
            end
        end
    endtask

    task automatic test_abort_ignored_start();
        int qv [20] = '{1, 2, 3, 4, 5, 5, 4, 3, 2, 1, 1, 1, 2, 3, 4, 5, 5, 4, 4, 4};
        int uv [20] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 0, 0};
        obs_t got, exp;
        bus.lo = 16'd1; bus.hi = 16'd5; bus.dwell = 8'd1; bus.n_sweeps = 8'd0;
        bus.start = 1'b1;
        for (int i = 0; i < 20; i++)
            sb.push_back(mk(qv[i], uv[i], (i < 18) ? 1 : 0, 0, 0, (i >= 9) ? 1 : 0));
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            exp = sb.pop_front(); got = observe(); n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL abort_run[%0d]: got %s, want %s", i, fmt(got), fmt(exp));
            end
            bus.start = (i == 1);
            if (i == 1) begin
                bus.lo = 16'd0; bus.hi = 16'd9; bus.dwell = 8'd0; bus.n_sweeps = 8'd1;
            end
            bus.abort = (i == 17);
        end
    endtask

    task automatic test_reset_mid_run();
        obs_t got, exp;
        bus.lo = 16'd1; bus.hi = 16'd8; bus.dwell = 8'd0; bus.n_sweeps = 8'd1;
        bus.start = 1'b1;
        sb.push_back(mk(1, 1, 1, 0, 0, 0));
        sb.push_back(mk(2, 1, 1, 0, 0, 0));
        sb.push_back(mk(3, 1, 1, 0, 0, 0));
        sb.push_back(mk(0, 1, 0, 0, 0, 0));
        sb.push_back(mk(0, 1, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            exp = sb.pop_front(); got = observe(); n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset_mid_run[%0d]: got %s, want %s", i, fmt(got), fmt(exp));
            end
            bus.start = 1'b0;
            reset = (i == 2);
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0;
        bus.lo = '0; bus.hi = '0; bus.dwell = '0; bus.n_sweeps = '0;
        @(posedge clk); #1;
        test_reset();
        test_single_sweep();
        test_two_sweeps();
        test_reject();
        test_abort_ignored_start();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
